// File: rtl/ula_cla_pipe.sv
// ula_cla_pipe: two-stage valid/ready ALU with a hierarchical carry-lookahead adder.
// Define ULA_SAT_EN to turn seletor 111 into saturating signed ADD.
module ula_cla_pipe #(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       seletor,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] resultado,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negativo,
  output logic             propagado,
  output logic             gerado
);
  localparam int NG = WIDTH / BLOCK;
  logic             s1_valid, s1_cin, s2_adv, s1_adv;
  logic [WIDTH-1:0] s1_a, s1_b, s1_g, s1_p, b_eff;
  logic [2:0]       s1_sel;
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !rst;
  assign b_eff    = seletor == 3'b101 ? ~B : B;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_sel   <= '0;
      s1_cin   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= A;
        s1_b   <= B;
        s1_g   <= A & b_eff;
        s1_p   <= A | b_eff;
        s1_sel <= seletor;
        s1_cin <= carry_in;
      end
    end
  end
  logic              cin_eff, bx_msb, cc, wg, ovf, sat_op, arith;
  logic [NG-1:0]     gg, pg;
  logic [NG:0]       gc;
  logic [WIDTH-1:0]  c, sum, sat_res, res;
  assign cin_eff = s1_sel == 3'b101 || s1_cin;
  assign bx_msb  = s1_sel == 3'b101 ? ~s1_b[WIDTH-1] : s1_b[WIDTH-1];
  // gc holds the group carries; wg chains the same groups with a zero carry-in
  always_comb begin
    gg = '0;
    pg = '1;
    gc = '0;
    c  = '0;
    cc = 1'b0;
    wg = 1'b0;
    gc[0] = cin_eff;
    for (int k = 0; k < NG; k++) begin
      cc = gc[k];
      for (int i = 0; i < BLOCK; i++) begin
        c[k*BLOCK+i] = cc;
        cc    = s1_g[k*BLOCK+i] | (s1_p[k*BLOCK+i] & cc);
        gg[k] = s1_g[k*BLOCK+i] | (s1_p[k*BLOCK+i] & gg[k]);
        pg[k] = pg[k] & s1_p[k*BLOCK+i];
      end
      gc[k+1] = gg[k] | (pg[k] & gc[k]);
      wg      = gg[k] | (pg[k] & wg);
    end
  end
  // with P = A|B' and G = A&B', P & ~G is the half-sum A^B'
  assign sum     = (s1_p & ~s1_g) ^ c;
  assign ovf     = (s1_a[WIDTH-1] == bx_msb) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
  assign sat_res = ovf ? (s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : sum;
`ifdef ULA_SAT_EN
  assign sat_op = s1_sel == 3'b111;
`else
  assign sat_op = 1'b0;
`endif
  assign arith = s1_sel == 3'b100 || s1_sel == 3'b101 || sat_op;
  assign res = s1_sel == 3'b000 ? s1_a & s1_b :
               s1_sel == 3'b001 ? s1_a | s1_b :
               s1_sel == 3'b010 ? ~s1_a :
               s1_sel == 3'b011 ? ~(s1_a & s1_b) :
               s1_sel == 3'b110 ? s1_a ^ s1_b :
               s1_sel == 3'b111 ? (sat_op ? sat_res : '0) : sum;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      resultado <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negativo  <= 1'b0;
      propagado <= 1'b0;
      gerado    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        resultado <= res;
        carry_out <= arith & gc[NG];
        overflow  <= arith & ovf;
        zero      <= res == '0;
        negativo  <= res[WIDTH-1];
        propagado <= arith & (&s1_p);
        gerado    <= arith & wg;
      end
    end
  end
endmodule
